// File: rtl/blk130_pkg.sv
// Shared constants and lock-state type for the multi-lane 128b/130b block-sync decoder.
package blk130_pkg;

    localparam int HDR_W = 2;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTRL = 2'b10;

    typedef enum logic [0:0] {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

endpackage

// File: rtl/blk_sync_lane.sv
// One lane: sync-header strip/classify, block-lock FSM and header-error window.
// Optional per-lane saturating error counter under BLK_SYNC_ERR_CNT_EN.
module blk_sync_lane
    import blk130_pkg::*;
#(
    parameter int PAYLOAD_W = 128,
    parameter int LOCK_GOOD = 4,
    parameter int BAD_WIN   = 64,
    parameter int BAD_LIMIT = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PAYLOAD_W+HDR_W-1:0] blk_in,
    input  logic                       valid_in,
    output logic [PAYLOAD_W-1:0]       data_out,
    output logic                       block_type,
    output logic                       hdr_err,
    output logic                       valid_out,
    output logic                       lane_lock,
    output logic                       lock_next
`ifdef BLK_SYNC_ERR_CNT_EN
    ,
    output logic [15:0]                err_cnt
`endif
);

    localparam int GOOD_W = $clog2(LOCK_GOOD) + 1;
    localparam int WIN_W  = $clog2(BAD_WIN) + 1;
    localparam int BAD_W  = $clog2(BAD_LIMIT) + 1;

    lock_state_e          state_q, state_d;
    logic [GOOD_W-1:0]    good_cnt_q, good_cnt_d;
    logic [WIN_W-1:0]     win_cnt_q, win_cnt_d;
    logic [BAD_W-1:0]     bad_cnt_q, bad_cnt_d;
    logic [PAYLOAD_W-1:0] data_q, data_d;
    logic                 type_q, type_d;
    logic                 err_q, err_d;
    logic                 vout_q, vout_d;
    logic [HDR_W-1:0]     hdr_s;
    logic                 hdr_ok_s;
`ifdef BLK_SYNC_ERR_CNT_EN
    logic [15:0]          err_cnt_q, err_cnt_d;
`endif

    // Next-state, counters and decoded block for this lane
    always_comb begin
        hdr_s      = blk_in[PAYLOAD_W+HDR_W-1 -: HDR_W];
        hdr_ok_s   = (hdr_s == SYNC_DATA) || (hdr_s == SYNC_CTRL);
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        win_cnt_d  = win_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        data_d     = data_q;
        type_d     = type_q;
        err_d      = 1'b0;
        vout_d     = 1'b0;
        if (valid_in) begin
            vout_d = (state_q == LOCKED);
            err_d  = !hdr_ok_s;
            case (hdr_s)
                SYNC_DATA: begin data_d = blk_in[PAYLOAD_W-1:0]; type_d = 1'b0; end
                SYNC_CTRL: begin data_d = blk_in[PAYLOAD_W-1:0]; type_d = 1'b1; end
                default:   begin data_d = '0;                    type_d = 1'b0; end
            endcase
            case (state_q)
                UNLOCKED: begin
                    if (!hdr_ok_s) begin
                        good_cnt_d = '0;
                    end else if (good_cnt_q + GOOD_W'(1) == GOOD_W'(LOCK_GOOD)) begin
                        state_d    = LOCKED;
                        good_cnt_d = '0;
                        win_cnt_d  = '0;
                        bad_cnt_d  = '0;
                    end else begin
                        good_cnt_d = good_cnt_q + GOOD_W'(1);
                    end
                end
                LOCKED: begin
                    // The window-closing block's own error is absorbed by the clear
                    if (!hdr_ok_s && (bad_cnt_q + BAD_W'(1) == BAD_W'(BAD_LIMIT))) begin
                        state_d    = UNLOCKED;
                        good_cnt_d = '0;
                        win_cnt_d  = '0;
                        bad_cnt_d  = '0;
                    end else if (win_cnt_q == WIN_W'(BAD_WIN - 1)) begin
                        win_cnt_d = '0;
                        bad_cnt_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + WIN_W'(1);
                        bad_cnt_d = hdr_ok_s ? bad_cnt_q : bad_cnt_q + BAD_W'(1);
                    end
                end
                default: begin
                    state_d = UNLOCKED;
                end
            endcase
        end else begin
            err_d  = 1'b0;
            vout_d = 1'b0;
        end
    end

`ifdef BLK_SYNC_ERR_CNT_EN
    // Saturating count of header errors, cleared only by reset
    always_comb begin
        if (err_d && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end
`endif

    // Lane state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= UNLOCKED;
            good_cnt_q <= '0;
            win_cnt_q  <= '0;
            bad_cnt_q  <= '0;
            data_q     <= '0;
            type_q     <= 1'b0;
            err_q      <= 1'b0;
            vout_q     <= 1'b0;
`ifdef BLK_SYNC_ERR_CNT_EN
            err_cnt_q  <= 16'd0;
`endif
        end else begin
            state_q    <= state_d;
            good_cnt_q <= good_cnt_d;
            win_cnt_q  <= win_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
            data_q     <= data_d;
            type_q     <= type_d;
            err_q      <= err_d;
            vout_q     <= vout_d;
`ifdef BLK_SYNC_ERR_CNT_EN
            err_cnt_q  <= err_cnt_d;
`endif
        end
    end

    assign data_out   = data_q;
    assign block_type = type_q;
    assign hdr_err    = err_q;
    assign valid_out  = vout_q;
    assign lane_lock  = (state_q == LOCKED);
    assign lock_next  = rst ? 1'b0 : (state_d == LOCKED);
`ifdef BLK_SYNC_ERR_CNT_EN
    assign err_cnt    = err_cnt_q;
`endif

endmodule

// File: rtl/blk_sync_decoder_130b.sv
// Multi-lane 128b/130b block-sync decoder: slices lane buses and forms all_lock.
// Optional per-lane err_cnt output under BLK_SYNC_ERR_CNT_EN.
module blk_sync_decoder_130b
    import blk130_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int PAYLOAD_W = 128,
    parameter int LOCK_GOOD = 4,
    parameter int BAD_WIN   = 64,
    parameter int BAD_LIMIT = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [LANES*(PAYLOAD_W+HDR_W)-1:0] blk_in,
    input  logic [LANES-1:0]                   valid_in,
    output logic [LANES*PAYLOAD_W-1:0]         data_out,
    output logic [LANES-1:0]                   block_type,
    output logic [LANES-1:0]                   hdr_err,
    output logic [LANES-1:0]                   valid_out,
    output logic [LANES-1:0]                   lane_lock,
    output logic                               all_lock
`ifdef BLK_SYNC_ERR_CNT_EN
    ,
    output logic [LANES*16-1:0]                err_cnt
`endif
);

    localparam int BLK_W = PAYLOAD_W + HDR_W;

    logic [LANES-1:0] lock_next_s;
    logic             all_lock_q, all_lock_d;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        blk_sync_lane #(
            .PAYLOAD_W (PAYLOAD_W),
            .LOCK_GOOD (LOCK_GOOD),
            .BAD_WIN   (BAD_WIN),
            .BAD_LIMIT (BAD_LIMIT)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .blk_in     (blk_in[i*BLK_W +: BLK_W]),
            .valid_in   (valid_in[i]),
            .data_out   (data_out[i*PAYLOAD_W +: PAYLOAD_W]),
            .block_type (block_type[i]),
            .hdr_err    (hdr_err[i]),
            .valid_out  (valid_out[i]),
            .lane_lock  (lane_lock[i]),
            .lock_next  (lock_next_s[i])
`ifdef BLK_SYNC_ERR_CNT_EN
            ,
            .err_cnt    (err_cnt[i*16 +: 16])
`endif
        );
    end

    // Aggregate lock from the lanes' next state so it updates with lane_lock
    always_comb begin
        all_lock_d = &lock_next_s;
    end

    // Registered all-lanes-locked flag
    always_ff @(posedge clk) begin
        if (rst) begin
            all_lock_q <= 1'b0;
        end else begin
            all_lock_q <= all_lock_d;
        end
    end

    assign all_lock = all_lock_q;

endmodule

// File: tb/tb_blk_sync_decoder_130b.sv
// Directed bench for blk_sync_decoder_130b (4 lanes, default parameters).
module tb_blk_sync_decoder_130b;

    logic         clk;
    logic         rst;
    logic [519:0] blk_in;
    logic [3:0]   valid_in;
    logic [511:0] data_out;
    logic [3:0]   block_type;
    logic [3:0]   hdr_err;
    logic [3:0]   valid_out;
    logic [3:0]   lane_lock;
    logic         all_lock;
`ifdef BLK_SYNC_ERR_CNT_EN
    logic [63:0]  err_cnt;
`endif

    int total = 0;
    int bad   = 0;

    blk_sync_decoder_130b dut (
        .clk        (clk),
        .rst        (rst),
        .blk_in     (blk_in),
        .valid_in   (valid_in),
        .data_out   (data_out),
        .block_type (block_type),
        .hdr_err    (hdr_err),
        .valid_out  (valid_out),
        .lane_lock  (lane_lock),
        .all_lock   (all_lock)
`ifdef BLK_SYNC_ERR_CNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [519:0] obs, input logic [519:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int l, input logic [1:0] h, input logic [127:0] p);
        valid_in = 4'b0000;
        blk_in[l*130 +: 130] = {h, p};
        valid_in[l] = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 4'b0000;
    endtask

    task automatic idle();
        valid_in = 4'b0000;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        blk_in   = '0;
        valid_in = 4'b0000;
        idle();
        idle();
        check("rst_valid_out", valid_out, 4'b0000);
        check("rst_lane_lock", lane_lock, 4'b0000);
        check("rst_all_lock", all_lock, 1'b0);
        check("rst_data_out", data_out, 512'd0);
        check("rst_hdr_err", hdr_err, 4'b0000);
        rst = 1'b0;

        // Lock acquire on lane 0
        for (int k = 0; k < 3; k++) begin
            send(0, 2'b01, 128'(k));
            check("acq_no_lock", lane_lock[0], 1'b0);
            check("acq_no_valid", valid_out[0], 1'b0);
        end
        send(0, 2'b01, 128'd3);
        check("acq_lock4", lane_lock, 4'b0001);
        check("acq_lockblk_not_out", valid_out, 4'b0000);
        send(0, 2'b01, 128'hA5A5);
        check("acq_first_valid", valid_out, 4'b0001);
        check("acq_first_data", data_out[127:0], 128'hA5A5);
        check("acq_first_type", block_type[0], 1'b0);

        // Control/data classification
        send(0, 2'b10, 128'h1234);
        check("cls_ctrl_type", block_type[0], 1'b1);
        check("cls_ctrl_data", data_out[127:0], 128'h1234);
        check("cls_ctrl_valid", valid_out[0], 1'b1);
        send(0, 2'b01, 128'h5678);
        check("cls_data_type", block_type[0], 1'b0);
        check("cls_data_data", data_out[127:0], 128'h5678);
        idle();
        check("idle_valid", valid_out, 4'b0000);
        check("idle_hold_data", data_out[127:0], 128'h5678);
        check("idle_hdr_err", hdr_err, 4'b0000);

        // Interrupted acquire on lane 1
        for (int k = 0; k < 3; k++) send(1, 2'b01, 128'(k + 16));
        send(1, 2'b11, 128'hDEAD);
        check("int_hdr_err", hdr_err, 4'b0010);
        check("int_zero_data", data_out[255:128], 128'd0);
        check("int_no_lock", lane_lock[1], 1'b0);
        for (int k = 0; k < 3; k++) begin
            send(1, 2'b01, 128'(k + 32));
            check("int_err_pulse", hdr_err[1], 1'b0);
            check("int_still_unlocked", lane_lock[1], 1'b0);
        end
        send(1, 2'b01, 128'd99);
        check("int_lock", lane_lock, 4'b0011);

        // Lock lanes 2 and 3
        for (int k = 0; k < 4; k++) send(2, 2'b10, 128'(k));
        check("l2_lock", lane_lock, 4'b0111);
        check("all_lock_pre", all_lock, 1'b0);
        for (int k = 0; k < 4; k++) send(3, 2'b01, 128'(k));
        check("all_lock_set", all_lock, 1'b1);

        // Loss of lock on lane 2
        for (int k = 0; k < 7; k++) begin
            send(2, 2'b00, 128'hBEEF);
            check("los_hold", lane_lock[2], 1'b1);
            check("los_err", hdr_err[2], 1'b1);
        end
        send(2, 2'b00, 128'hBEEF);
        check("los_8th_valid", valid_out, 4'b0100);
        check("los_8th_err", hdr_err, 4'b0100);
        check("los_8th_data", data_out[383:256], 128'd0);
        check("los_unlock", lane_lock, 4'b1011);
        check("los_all_lock", all_lock, 1'b0);

        // Window reset on lane 3: 7 bad at end of window 1, 7 bad at start of window 2
        for (int k = 0; k < 57; k++) send(3, 2'b01, 128'(k));
        for (int k = 0; k < 7; k++) send(3, 2'b11, 128'(k));
        check("win1_lock", lane_lock[3], 1'b1);
        for (int k = 0; k < 7; k++) send(3, 2'b00, 128'(k));
        check("win2_bad_lock", lane_lock[3], 1'b1);
        check("win2_valid", valid_out[3], 1'b1);
        for (int k = 0; k < 57; k++) send(3, 2'b10, 128'(k));
        check("win2_lock", lane_lock[3], 1'b1);
        check("win2_type", block_type[3], 1'b1);

        // Bad headers on locked lane 0, then reset mid-burst
        for (int k = 0; k < 3; k++) send(0, 2'b11, 128'(k));
        check("bad3_lock", lane_lock[0], 1'b1);
`ifdef BLK_SYNC_ERR_CNT_EN
        check("errcnt_l0", err_cnt[15:0], 16'd3);
        check("errcnt_l1", err_cnt[31:16], 16'd1);
        check("errcnt_l3", err_cnt[63:48], 16'd14);
`endif
        for (int l = 0; l < 4; l++) blk_in[l*130 +: 130] = {2'b01, 128'(l + 7)};
        valid_in = 4'b1111;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mrst_valid", valid_out, 4'b0000);
        check("mrst_lock", lane_lock, 4'b0000);
        check("mrst_all_lock", all_lock, 1'b0);
        check("mrst_data", data_out, 512'd0);
        check("mrst_type", block_type, 4'b0000);
        check("mrst_err", hdr_err, 4'b0000);
`ifdef BLK_SYNC_ERR_CNT_EN
        check("mrst_errcnt", err_cnt, 64'd0);
`endif
        for (int k = 0; k < 3; k++) begin
            send(0, 2'b01, 128'(k));
            check("reacq_no_lock", lane_lock[0], 1'b0);
            check("reacq_no_valid", valid_out[0], 1'b0);
        end
        send(0, 2'b01, 128'd3);
        check("reacq_lock", lane_lock, 4'b0001);
        check("reacq_lockblk", valid_out[0], 1'b0);
        send(0, 2'b01, 128'hC0DE);
        check("reacq_valid", valid_out, 4'b0001);
        check("reacq_data", data_out[127:0], 128'hC0DE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
